// File: rtl/conv3x3_stream_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// conv3x3_stream_ctrl_pkg
// Shared definitions for the 3x3 convolution stream controller and its core:
// kernel tap count, coefficient/output widths, controller state encoding and
// a helper that unpacks the flat 72-bit kernel bus into per-tap coefficients.
// Optional feature macro used by the users of this package: SAT_CNT_EN.
// ---------------------------------------------------------------------------
package conv3x3_stream_ctrl_pkg;

   localparam int TAPS   = 9;
   localparam int COEF_W = 8;
   localparam int OUT_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef logic signed [COEF_W-1:0] coef_t;
   typedef coef_t [TAPS-1:0]         taps_t;

   // Tap index i = row*3 + col, row 0 on top; k00 sits in the top byte.
   function automatic taps_t unpack_kernel(input logic [TAPS*COEF_W-1:0] k);
      taps_t t;
      for (int i = 0; i < TAPS; i++) begin
         t[i] = k[(TAPS-1-i)*COEF_W +: COEF_W];
      end
      return t;
   endfunction

endpackage

// File: rtl/conv3x3_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv3x3_stream_ctrl_if
// Pixel input stream and result output stream of the 3x3 convolution
// controller, bundled as one interface.
//   s_valid/s_ready/s_data : raster-order pixel stream into the controller
//   m_valid/m_ready/m_data/m_last : result stream out of the controller
// Modports: master = pixel source + result sink side, slave = controller.
// ---------------------------------------------------------------------------
interface conv3x3_stream_ctrl_if #(
   parameter int BITW = 8
);
   import conv3x3_stream_ctrl_pkg::*;

   logic             s_valid;
   logic             s_ready;
   logic [BITW-1:0]  s_data;
   logic             m_valid;
   logic             m_ready;
   logic [OUT_W-1:0] m_data;
   logic             m_last;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

endinterface

// File: rtl/conv3x3_comb.sv
// ---------------------------------------------------------------------------
// conv3x3_comb
// Combinational 3x3 convolution core: unsigned pixels (zero-extended),
// signed 8-bit coefficients, ACCW-bit signed accumulation, absolute value,
// saturation to 0..255.
// Ports:
//   win  : 9 pixels, index row*3+col, row 0 on top
//   taps : 9 signed coefficients, same indexing
//   res  : |sum| clamped to 0..255
//   sat  : |sum| > 255 before clamping (only when SAT_CNT_EN is defined)
// ---------------------------------------------------------------------------
module conv3x3_comb
   import conv3x3_stream_ctrl_pkg::*;
#(
   parameter int BITW = 8,
   parameter int ACCW = 20
) (
   input  logic [TAPS-1:0][BITW-1:0] win,
   input  taps_t                     taps,
   output logic [OUT_W-1:0]          res
`ifdef SAT_CNT_EN
   ,
   output logic                      sat
`endif
);

   function automatic logic [ACCW-1:0] abs_acc(input logic signed [ACCW-1:0] v);
      logic [ACCW-1:0] r;
      if (v[ACCW-1]) r = $unsigned(-v);
      else           r = $unsigned(v);
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] sat_out(input logic [ACCW-1:0] m);
      return (m > ACCW'((1 << OUT_W) - 1)) ? {OUT_W{1'b1}} : m[OUT_W-1:0];
   endfunction

   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] px;
   logic signed [ACCW-1:0] cf;
   logic        [ACCW-1:0] mag;

   always_comb begin
      acc = '0;
      px  = '0;
      cf  = '0;
      for (int i = 0; i < TAPS; i++) begin
         px  = $signed({{(ACCW-BITW){1'b0}}, win[i]});
         cf  = $signed({{(ACCW-COEF_W){taps[i][COEF_W-1]}}, taps[i]});
         acc = acc + px * cf;
      end
   end

   assign mag = abs_acc(acc);
   assign res = sat_out(mag);
`ifdef SAT_CNT_EN
   assign sat = (mag > ACCW'((1 << OUT_W) - 1));
`endif

endmodule

// File: rtl/conv3x3_stream_ctrl.sv
// ---------------------------------------------------------------------------
// conv3x3_stream_ctrl
// Frame controller that runs a raster pixel stream through two line buffers
// and a 3x3 window into conv3x3_comb, emitting one result per interior pixel
// ((IMG_W-2)*(IMG_H-2) per frame) with full valid/ready backpressure.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, starts a frame when idle (kernel latched)
//   k_flat     : 9 signed 8-bit coefficients, k00 at [71:64]
//   busy, done : frame in progress / one-cycle end-of-frame pulse
//   io         : pixel in / result out streams (slave modport)
//   sat_cnt    : results clamped this frame (only when SAT_CNT_EN is defined)
// ---------------------------------------------------------------------------
module conv3x3_stream_ctrl
   import conv3x3_stream_ctrl_pkg::*;
#(
   parameter int BITW  = 8,
   parameter int ACCW  = 20,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [TAPS*COEF_W-1:0]   k_flat,
   output logic                     busy,
   output logic                     done,
   conv3x3_stream_ctrl_if.slave     io
`ifdef SAT_CNT_EN
   ,
   output logic [31:0]              sat_cnt
`endif
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   state_t                    state, state_nxt;
   logic [CW-1:0]             col;
   logic [RW-1:0]             row;
   taps_t                     taps_p0;
   logic [BITW-1:0]           lb0 [IMG_W];
   logic [BITW-1:0]           lb1 [IMG_W];
   logic [TAPS-1:0][BITW-1:0] win_p0, win_nxt;
   logic                      start_acc, accept, last_pix, fire;
   logic [OUT_W-1:0]          core_res;
   logic                      vld_p1, last_p1;
   logic [OUT_W-1:0]          data_p1;
`ifdef SAT_CNT_EN
   logic                      core_sat, sat_p1;
`endif

   assign start_acc  = (state == ST_IDLE) && start;
   assign io.s_ready = (state == ST_RUN) && (!vld_p1 || io.m_ready);
   assign accept     = io.s_valid && io.s_ready;
   assign last_pix   = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
   // Columns carried across a line wrap are stale; col>=2 keeps them out.
   assign fire       = accept && (row >= RW'(2)) && (col >= CW'(2));

   assign io.m_valid = vld_p1;
   assign io.m_data  = data_p1;
   assign io.m_last  = last_p1;

   // ---- FSM ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN:   if (accept && last_pix)      state_nxt = ST_FLUSH;
         ST_FLUSH: if (!vld_p1 || io.m_ready)   state_nxt = ST_DONE;
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---- raster position ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (start_acc) begin
         row <= '0;
         col <= '0;
      end else if (accept) begin
         if (col == CW'(IMG_W-1)) begin
            col <= '0;
            row <= last_pix ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // ---- stage p0: kernel, line buffers, window ----
   always_comb begin
      win_nxt = win_p0;
      for (int r = 0; r < 3; r++) begin
         win_nxt[r*3]     = win_p0[r*3+1];
         win_nxt[r*3 + 1] = win_p0[r*3+2];
      end
      win_nxt[2] = lb1[col];
      win_nxt[5] = lb0[col];
      win_nxt[8] = io.s_data;
   end

   always_ff @(posedge clk) begin
      if (start_acc) taps_p0 <= unpack_kernel(k_flat);
      if (accept) begin
         lb1[col] <= lb0[col];
         lb0[col] <= io.s_data;
         win_p0   <= win_nxt;
      end
   end

   conv3x3_comb #(
      .BITW (BITW),
      .ACCW (ACCW)
   ) u_core (
      .win  (win_nxt),
      .taps (taps_p0),
      .res  (core_res)
`ifdef SAT_CNT_EN
      ,
      .sat  (core_sat)
`endif
   );

   // ---- stage p1: output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (fire) begin
         vld_p1  <= 1'b1;
         data_p1 <= core_res;
         last_p1 <= last_pix;
      end else if (io.m_ready) begin
         vld_p1  <= 1'b0;
      end
   end

`ifdef SAT_CNT_EN
   always_ff @(posedge clk) begin
      if (fire) sat_p1 <= core_sat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              sat_cnt <= '0;
      else if (start_acc)                      sat_cnt <= '0;
      else if (vld_p1 && io.m_ready && sat_p1) sat_cnt <= sat_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv3x3_stream_ctrl
// Self-checking bench for conv3x3_stream_ctrl on a 5x4 frame: table-driven
// kernel/pattern frames, randomized frames against a plain-arithmetic
// convolution model, and hand-written reset / restart sequences.
// Optional feature macro: SAT_CNT_EN (adds sat_cnt checks).
// ---------------------------------------------------------------------------
module tb_conv3x3_stream_ctrl;

   localparam int W = 5;
   localparam int H = 4;
   localparam int N = W * H;
   localparam logic [71:0] SOBEL_X = 72'hFF0001FE0002FF0001;
   localparam logic [71:0] ALL_2   = 72'h020202020202020202;
   localparam logic [71:0] ALL_M1  = 72'hFFFFFFFFFFFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [71:0] k_flat;
   logic        busy, done;
`ifdef SAT_CNT_EN
   logic [31:0] sat_cnt;
`endif

   conv3x3_stream_ctrl_if #(.BITW(8)) bus ();

   conv3x3_stream_ctrl #(
      .BITW (8), .ACCW (20), .IMG_W (W), .IMG_H (H)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .k_flat (k_flat),
      .busy   (busy),
      .done   (done),
      .io     (bus.slave)
`ifdef SAT_CNT_EN
      ,
      .sat_cnt(sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---- reference model ----
   int frm [H][W];
   int exp_d[$];
   int exp_l[$];
   int got_d[$];
   int got_l[$];
   int exp_sat;

   function automatic int kc(input logic [71:0] k, input int i);
      logic [7:0] b;
      b = k[71-8*i -: 8];
      return int'($signed(b));
   endfunction

   function automatic int pixval(input int pat, input int r, input int c);
      case (pat)
         0:       return c * 10;
         1:       return 100;
         2:       return ((r + c) % 2 == 1) ? 255 : 0;
         default: return 20;
      endcase
   endfunction

   task automatic model(input logic [71:0] k);
      int s, a;
      exp_d.delete();
      exp_l.delete();
      exp_sat = 0;
      for (int r = 1; r <= H - 2; r++) begin
         for (int c = 1; c <= W - 2; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += kc(k, i*3 + j) * frm[r-1+i][c-1+j];
            a = (s < 0) ? -s : s;
            if (a > 255) exp_sat++;
            exp_d.push_back((a > 255) ? 255 : a);
            exp_l.push_back((r == H - 2 && c == W - 2) ? 1 : 0);
         end
      end
   endtask

   // ---- output monitor (samples on the falling edge) ----
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit   hold_chk = 1'b0;
   int   hold_data;
   bit   done_seen;
   int   done_cnt, done_cyc, last_cyc;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            chk("hold_valid", int'(bus.m_valid), 1);
            chk("hold_data", int'(bus.m_data), hold_data);
         end
         if (bus.m_valid && bus.m_ready) begin
            got_d.push_back(int'(bus.m_data));
            got_l.push_back(int'(bus.m_last));
            if (bus.m_last) last_cyc = cyc;
         end
         hold_chk  = bus.m_valid && !bus.m_ready;
         hold_data = int'(bus.m_data);
         if (done) begin
            done_seen = 1'b1;
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // ---- one frame: start, stream, drain, compare ----
   task automatic run_frame(input int pat, input logic [71:0] k, input int gap,
                            input int stall, input bit twist);
      int idx, n;
      bit acc;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            frm[r][c] = (pat == 4) ? int'($urandom_range(255)) : pixval(pat, r, c);
      model(k);
      got_d.delete();
      got_l.delete();
      done_seen = 1'b0;
      done_cnt  = 0;
      k_flat = k;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (twist) k_flat = ~k;
      idx = 0;
      n   = 0;
      while (!done_seen && n < 3000) begin
         bus.s_valid = (idx < N) && ($urandom_range(99) >= gap);
         bus.s_data  = (idx < N) ? 8'(frm[idx / W][idx % W]) : 8'h00;
         bus.m_ready = ($urandom_range(99) >= stall);
         start       = twist && (n == 8);
         @(negedge clk);
         acc = bus.s_valid && bus.s_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         n++;
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      start       = 1'b0;
      chk("frame_done_seen", int'(done_seen), 1);
      chk("busy_after_done", int'(busy), 0);
      chk("result_count", got_d.size(), exp_d.size());
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         chk("result_data", got_d[i], exp_d[i]);
         chk("result_last", got_l[i], exp_l[i]);
      end
      chk("done_pulses", done_cnt, 1);
      chk("done_latency", done_cyc - last_cyc, 1);
`ifdef SAT_CNT_EN
      chk("sat_cnt", int'(sat_cnt), exp_sat);
`endif
   endtask

   typedef struct {
      int          pat;
      logic [71:0] k;
      int          exp_val;
      int          exp_sat;
   } vec_t;

   vec_t tbl [4];

   initial begin
      logic [71:0] rk;

      tbl[0] = '{pat: 0, k: SOBEL_X, exp_val: 80,  exp_sat: 0};
      tbl[1] = '{pat: 1, k: SOBEL_X, exp_val: 0,   exp_sat: 0};
      tbl[2] = '{pat: 2, k: ALL_2,   exp_val: 255, exp_sat: 6};
      tbl[3] = '{pat: 3, k: ALL_M1,  exp_val: 180, exp_sat: 0};

      rst_n = 1'b0; start = 1'b0; k_flat = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
      #3;
      chk("rst_busy",    int'(busy), 0);
      chk("rst_done",    int'(done), 0);
      chk("rst_s_ready", int'(bus.s_ready), 0);
      chk("rst_m_valid", int'(bus.m_valid), 0);
      chk("rst_m_data",  int'(bus.m_data), 0);
      chk("rst_m_last",  int'(bus.m_last), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // table-driven frames, no stalls
      for (int t = 0; t < 4; t++) begin
         run_frame(tbl[t].pat, tbl[t].k, 0, 0, 1'b0);
         for (int i = 0; i < got_d.size(); i++)
            chk("table_value", got_d[i], tbl[t].exp_val);
`ifdef SAT_CNT_EN
         chk("table_sat_cnt", int'(sat_cnt), tbl[t].exp_sat);
`endif
      end

      // randomized frames with input gaps and output stalls
      for (int f = 0; f < 4; f++) begin
         rk = '0;
         for (int b = 0; b < 9; b++) rk = {rk[63:0], 8'($urandom_range(255))};
         run_frame(4, rk, 30, 50, 1'b0);
      end

      // second start mid-frame and kernel change mid-frame must be ignored
      rk = '0;
      for (int b = 0; b < 9; b++) rk = {rk[63:0], 8'($urandom_range(255))};
      run_frame(4, rk, 20, 30, 1'b1);

      // reset in the middle of a frame with a result pending
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) frm[r][c] = pixval(0, r, c);
      k_flat = SOBEL_X; start = 1'b1; bus.m_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 13; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(frm[i / W][i % W]);
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      chk("pre_rst_m_valid", int'(bus.m_valid), 1);
      chk("pre_rst_m_data",  int'(bus.m_data), 80);
      chk("pre_rst_busy",    int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy",    int'(busy), 0);
      chk("midrst_done",    int'(done), 0);
      chk("midrst_s_ready", int'(bus.s_ready), 0);
      chk("midrst_m_valid", int'(bus.m_valid), 0);
      chk("midrst_m_data",  int'(bus.m_data), 0);
      chk("midrst_m_last",  int'(bus.m_last), 0);
`ifdef SAT_CNT_EN
      chk("midrst_sat_cnt", int'(sat_cnt), 0);
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // a full frame after the mid-frame reset
      run_frame(0, SOBEL_X, 10, 20, 1'b0);
      for (int i = 0; i < got_d.size(); i++)
         chk("post_rst_value", got_d[i], 80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv3x3_stream_ctrl.md
Name: conv3x3_stream_ctrl

Overview:
Frame-level controller that sequences the combinational 3x3 convolution core over a raster-scanned image stream. It holds two line buffers and a 3x3 window register, latches the kernel at frame start, and presents one windowed result per interior pixel. Input and output are valid/ready streams with full backpressure. It sits between the pixel source (camera/DMA reader) and the result sink (frame writer).

Parameters:
BITW, 8, input pixel width (unsigned)
ACCW, 20, core accumulator width, passed to the core
IMG_W, 640, frame width in pixels, minimum 3
IMG_H, 480, frame height in lines, minimum 3

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when IDLE
k_flat  in  72  kernel k00..k22 packed, signed 8b each; k00 at [71:64]
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last output handshake
s_valid  in  1  input pixel valid
s_ready  out  1  controller accepts pixel
s_data  in  BITW  input pixel, raster order
m_valid  out  1  result valid
m_ready  in  1  sink accepts result
m_data  out  8  |sum| clamped to 0..255
m_last  out  1  marks final result of the frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, s_ready=0, m_valid=0, m_data=0, m_last=0; row/col counters=0. Line-buffer contents are don't-care.
- States: IDLE -> RUN on start (kernel latched in that same cycle). RUN -> FLUSH when the last pixel (row IMG_H-1, col IMG_W-1) is accepted. FLUSH -> DONE when the output register empties. DONE -> IDLE after 1 cycle with done=1.
- start while busy is ignored. A k_flat change during a frame has no effect.
- s_ready = (state==RUN) && (!m_valid || m_ready). A pixel is accepted when s_valid && s_ready.
- On each accept:
  - Shift the window left.
  - New right column = {linebuf1[col], linebuf0[col], s_data}, top to bottom.
  - Write linebuf1[col] <= linebuf0[col] and linebuf0[col] <= s_data.
  - Advance col; it wraps at IMG_W-1 and row increments.
- Output generated only when the accepted pixel has row>=2 and col>=2. The window is then centred at (row-1, col-1). There is no border padding, so a frame yields (IMG_W-2)*(IMG_H-2) results.
- Latency: the result is registered into m_data/m_valid on the cycle after the accept. The window is fed to the core combinationally from its next-state value.
- m_valid holds with m_data stable until m_ready. A simultaneous new result and handshake replaces the register with no bubble.
- Window columns carried across a line wrap are stale. They are never used, because output requires col>=2.
- m_last=1 with the result at row IMG_H-1, col IMG_W-1.
- Arithmetic is the core's: pixels zero-extended to signed, signed 8b coefficients, ACCW accumulation, absolute value, saturate to 255.
- Throughput: 1 pixel/clk when unstalled.

Optional Feature:
SAT_CNT_EN defined: adds output port sat_cnt (32 bits).
- Increments on each output handshake whose pre-clamp |sum| > 255.
- Clears on start accept and on reset.
- Holds its value after done.
SAT_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: kernel tap-count constant (9), coefficient width (8), output width (8), state encoding (IDLE/RUN/FLUSH/DONE), and a function unpacking k_flat into taps.
- One sub-module instance: the existing combinational core conv3x3_comb (BITW, ACCW passed through).
- Line buffers are inferred arrays inside this block, not separate modules.

Test Plan:
- IMG_W=5, IMG_H=4. Pixel = col*10. Sobel X kernel (-1,0,1;-2,0,2;-1,0,1). Expect 6 results, all 80; m_last on the 6th; done one cycle after it.
- Constant 100 frame with Sobel X -> 6 results of 0.
- Checkerboard 0/255 with kernel all 2 -> every result 255. With SAT_CNT_EN, sat_cnt=6.
- Random m_ready (50%), random s_valid gaps -> result sequence matches golden model; m_data never changes while m_valid && !m_ready.
- rst_n low mid-frame (after 9 pixels) -> all outputs 0 immediately. A new start then processes a full frame correctly.
- Second start pulse during RUN is ignored. A k_flat change mid-frame does not alter results.
